// File: rtl/control_multiciclo_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: opcodes, ALU/mux selects, states.
package control_multiciclo_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_R_EXEC    = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_ADDI_EXEC = 4'd8;
  localparam logic [3:0] S_ADDI_WB   = 4'd9;
  localparam logic [3:0] S_BRANCH    = 4'd10;
  localparam logic [3:0] S_JUMP      = 4'd11;

endpackage

// File: rtl/control_multiciclo_watchdog_mem.sv
// Memory-wait watchdog: counts stalled cycles, pulses expire_o on the last allowed one.
// Expiry is combinational in the final stalled cycle so the FSM can abort that same cycle.
module watchdog_mem #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expire_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign expire_o = en_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || !en_i || expire_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/control_multiciclo.sv
// Main control FSM for the multicycle MIPS datapath (Moore outputs, mem_ready gates fetch enables).
// Every memory-wait state is guarded by watchdog_mem; expiry aborts back to FETCH.
module control_multiciclo
  import control_multiciclo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       i_or_d,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic       mem_timeout
);

  logic [3:0] state_q, state_d;
  logic       wait_st;
  logic       wd_expire;

  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_READ) || (state_q == S_MEM_WRITE);

  watchdog_mem #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk_i   (clk),
    .rst_i   (rst),
    .en_i    (wait_st && !mem_ready),
    .clr_i   (state_d != state_q),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
                   else if (wd_expire) state_d = S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
                   else if (wd_expire) state_d = S_FETCH;
      S_MEM_WRITE: if (mem_ready || wd_expire) state_d = S_FETCH;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_ADDI_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // While rst is high every output stays at its default 0, dropping any pending enable.
  always_comb begin
    pc_en       = 1'b0;
    i_or_d      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_B;
    alu_op      = ALUOP_ADD;
    pc_source   = PCSRC_ALU;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;
    if (!rst) begin
      mem_timeout = wd_expire;
      case (state_q)
        S_FETCH: begin
          mem_read  = !wd_expire;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_en     = mem_ready;
        end
        S_DECODE: begin
          alu_src_b = SRCB_IMM_SH;
          illegal_op = !(opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI});
        end
        S_MEM_ADDR, S_ADDI_EXEC: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          mem_read = !wd_expire;
          i_or_d   = 1'b1;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write = !wd_expire;
          i_or_d    = 1'b1;
        end
        S_R_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_FUNCT;
        end
        S_R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
        end
        S_ADDI_WB: reg_write = 1'b1;
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALUOP_SUB;
          pc_source = PCSRC_ALUOUT;
          pc_en     = zero;
        end
        S_JUMP: begin
          pc_source = PCSRC_JUMP;
          pc_en     = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: expected output vectors queued per step, checked after inputs settle.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, illegal_op, mem_timeout;
  logic [1:0] alu_src_b, alu_op, pc_source;

  int n_checks = 0;
  int n_fail   = 0;
  logic [16:0] exp_q[$];

  control_multiciclo dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .illegal_op(illegal_op), .mem_timeout(mem_timeout)
  );

  always #5 clk = ~clk;

  // Field order: pc_en i_or_d mem_read mem_write ir_write reg_dst mem_to_reg reg_write
  //              alu_src_a alu_src_b alu_op pc_source illegal_op mem_timeout
  function automatic logic [16:0] mk(input logic pe, input logic iod, input logic mr, input logic mw,
                                     input logic irw, input logic rd, input logic m2r, input logic rw,
                                     input logic asa, input logic [1:0] asb, input logic [1:0] aop,
                                     input logic [1:0] pcs, input logic ill, input logic to);
    return {pe, iod, mr, mw, irw, rd, m2r, rw, asa, asb, aop, pcs, ill, to};
  endfunction

  localparam logic [16:0] V_ZERO      = 17'd0;
  localparam logic [16:0] V_FETCH_NR  = mk(0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
  localparam logic [16:0] V_FETCH_R   = mk(1,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
  localparam logic [16:0] V_FETCH_TO  = mk(0,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,1);
  localparam logic [16:0] V_DECODE    = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
  localparam logic [16:0] V_DECODE_IL = mk(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,0);
  localparam logic [16:0] V_MEM_ADDR  = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
  localparam logic [16:0] V_MEM_READ  = mk(0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] V_MEM_WB    = mk(0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] V_MEM_WRITE = mk(0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] V_R_EXEC    = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
  localparam logic [16:0] V_R_WB      = mk(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] V_ADDI_EXEC = mk(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
  localparam logic [16:0] V_ADDI_WB   = mk(0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [16:0] V_BRANCH_Z0 = mk(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
  localparam logic [16:0] V_BRANCH_Z1 = mk(1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
  localparam logic [16:0] V_JUMP      = mk(1,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0,0);

  task automatic step(input string tag, input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input logic [16:0] expv);
    logic [16:0] got, want;
    @(negedge clk);
    rst = r; opcode = op; zero = z; mem_ready = mr;
    exp_q.push_back(expv);
    #1;
    got = {pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_source, illegal_op, mem_timeout};
    want = exp_q.pop_front();
    n_checks++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s observed=%05h expected=%05h", tag, got, want);
    end
  endtask

  initial begin
    // Reset holds every output low, even with mem_ready asserted.
    step("rst0", 1, 6'b000000, 0, 1, V_ZERO);
    step("rst1", 1, 6'b000000, 0, 1, V_ZERO);

    // R-type: FETCH, DECODE, R_EXEC, R_WB, back to FETCH on the 4th edge.
    step("r_fetch",  0, 6'b000000, 0, 1, V_FETCH_R);
    step("r_decode", 0, 6'b000000, 0, 1, V_DECODE);
    step("r_exec",   0, 6'b000000, 0, 1, V_R_EXEC);
    step("r_wb",     0, 6'b000000, 0, 1, V_R_WB);

    step("addi_fetch",  0, 6'b001000, 0, 1, V_FETCH_R);
    step("addi_decode", 0, 6'b001000, 0, 1, V_DECODE);
    step("addi_exec",   0, 6'b001000, 0, 1, V_ADDI_EXEC);
    step("addi_wb",     0, 6'b001000, 0, 1, V_ADDI_WB);

    // lw with memory ready only on the 4th MEM_READ cycle.
    step("lw_fetch",  0, 6'b100011, 0, 1, V_FETCH_R);
    step("lw_decode", 0, 6'b100011, 0, 1, V_DECODE);
    step("lw_addr",   0, 6'b100011, 0, 1, V_MEM_ADDR);
    for (int i = 0; i < 3; i++) step("lw_read_wait", 0, 6'b100011, 0, 0, V_MEM_READ);
    step("lw_read_done", 0, 6'b100011, 0, 1, V_MEM_READ);
    step("lw_wb",        0, 6'b100011, 0, 1, V_MEM_WB);

    step("sw_fetch",  0, 6'b101011, 0, 1, V_FETCH_R);
    step("sw_decode", 0, 6'b101011, 0, 1, V_DECODE);
    step("sw_addr",   0, 6'b101011, 0, 1, V_MEM_ADDR);
    step("sw_write",  0, 6'b101011, 0, 1, V_MEM_WRITE);

    step("beq0_fetch",  0, 6'b000100, 0, 1, V_FETCH_R);
    step("beq0_decode", 0, 6'b000100, 0, 1, V_DECODE);
    step("beq0_branch", 0, 6'b000100, 0, 1, V_BRANCH_Z0);
    step("beq1_fetch",  0, 6'b000100, 1, 1, V_FETCH_R);
    step("beq1_decode", 0, 6'b000100, 1, 1, V_DECODE);
    step("beq1_branch", 0, 6'b000100, 1, 1, V_BRANCH_Z1);

    step("j_fetch",  0, 6'b000010, 0, 1, V_FETCH_R);
    step("j_decode", 0, 6'b000010, 0, 1, V_DECODE);
    step("j_jump",   0, 6'b000010, 0, 1, V_JUMP);

    step("ill_fetch",  0, 6'b111111, 0, 1, V_FETCH_R);
    step("ill_decode", 0, 6'b111111, 0, 1, V_DECODE_IL);

    // Fetch stalls: timeout on the 16th cycle, then a cleared watchdog lets 15 more stall quietly.
    for (int i = 0; i < 15; i++) step("to_stall", 0, 6'b000000, 0, 0, V_FETCH_NR);
    step("to_expire", 0, 6'b000000, 0, 0, V_FETCH_TO);
    for (int i = 0; i < 15; i++) step("to_restart", 0, 6'b000000, 0, 0, V_FETCH_NR);
    step("to_ready_wins", 0, 6'b100011, 0, 1, V_FETCH_R);

    // Reset in the middle of a lw memory read.
    step("rr_decode", 0, 6'b100011, 0, 1, V_DECODE);
    step("rr_addr",   0, 6'b100011, 0, 1, V_MEM_ADDR);
    step("rr_read",   0, 6'b100011, 0, 0, V_MEM_READ);
    step("rr_rst0",   1, 6'b100011, 0, 0, V_ZERO);
    step("rr_rst1",   1, 6'b100011, 0, 0, V_ZERO);
    step("rr_fetch",  0, 6'b000000, 0, 0, V_FETCH_NR);
    step("rr_fetch_r", 0, 6'b000000, 0, 1, V_FETCH_R);
    step("rr_decode2", 0, 6'b000000, 0, 1, V_DECODE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
Name: control_multiciclo

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the instruction opcode and sequences fetch/decode/execute/memory/writeback across cycles.
- Drives `alu_op[1:0]` into the existing ALU control decoder, plus all mux selects and register/memory enables.
- Waits on a memory-ready handshake and guards each wait with a timeout watchdog.

Parameters:
- `TIMEOUT_CYCLES`, 16: max cycles spent in any memory-wait state before aborting (≥2).
- `CNT_W`, 5: width of the watchdog counter; must satisfy 2^`CNT_W` > `TIMEOUT_CYCLES`.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `opcode` input 6: IR[31:26], valid from DECODE onward.
- `zero` input 1: ALU zero flag.
- `mem_ready` input 1: memory completes current access this cycle.
- `pc_en` output 1: PC register write enable.
- `i_or_d` output 1: memory address select (0=PC, 1=ALUOut).
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `ir_write` output 1: instruction register load.
- `reg_dst` output 1: write register select (0=rt, 1=rd).
- `mem_to_reg` output 1: write data select (0=ALUOut, 1=MDR).
- `reg_write` output 1: register file write enable.
- `alu_src_a` output 1: ALU A select (0=PC, 1=A reg).
- `alu_src_b` output 2: ALU B select (00=B, 01=const 4, 10=signext imm, 11=signext imm<<2).
- `alu_op` output 2: to ALU control (00=add, 01=sub, 10=use function field).
- `pc_source` output 2: next PC select (00=ALU result, 01=ALUOut, 10=jump target).
- `illegal_op` output 1: one-cycle pulse on unsupported opcode.
- `mem_timeout` output 1: one-cycle pulse on watchdog expiry.

Behaviour:
- One clock, `clk`; reset `rst` is synchronous and active-high.
- On a reset edge: state=FETCH, watchdog=0.
- While `rst`=1, every output is forced to 0.
- Outputs are combinational from state (Moore). Exceptions: `pc_en`, `ir_write` are gated by `mem_ready`; `pc_en` in BRANCH is gated by `zero`.
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000.
- Unlisted outputs are 0 in each state.

States and transitions:
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00; `ir_write`=`pc_en`=`mem_ready`. `mem_ready`=1 → DECODE, else stay.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (precompute branch target).
  - lw/sw → MEM_ADDR; R → R_EXEC; beq → BRANCH; j → JUMP; addi → ADDI_EXEC.
  - Other opcode → `illegal_op` pulse, → FETCH.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. lw → MEM_READ, sw → MEM_WRITE.
- MEM_READ: `mem_read`=1, `i_or_d`=1. `mem_ready` → MEM_WB.
- MEM_WB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0. → FETCH.
- MEM_WRITE: `mem_write`=1, `i_or_d`=1. `mem_ready` → FETCH.
- R_EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10. → R_WB.
- R_WB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0. → FETCH.
- ADDI_EXEC: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00. → ADDI_WB.
- ADDI_WB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0. → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_source`=01, `pc_en`=`zero`. → FETCH.
- JUMP: `pc_source`=10, `pc_en`=1. → FETCH.

Watchdog:
- Counts each cycle spent in FETCH/MEM_READ/MEM_WRITE with `mem_ready`=0.
- Clears on any state change or when `mem_ready`=1.
- When count reaches `TIMEOUT_CYCLES`−1 and `mem_ready` is still 0: `mem_timeout` pulses, state → FETCH, no `pc_en`/`ir_write`/`reg_write` issued, request dropped that cycle.
- `mem_ready`=1 on the expiry cycle wins: normal completion, no timeout.

Latencies (rising edges, `mem_ready` always 1):
- R, addi: 4.
- lw: 5.
- sw, beq, j: 4, 3, 3.

Reset mid-instruction: any state → FETCH on the next edge; pending write enables drop immediately, since outputs are forced to 0 while `rst`=1.

Decomposition:
- Shared package holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI);
  - `alu_op` encodings (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT);
  - `alu_src_b` and `pc_source` encodings;
  - the 4-bit state encoding.
- One sub-module is natural: `watchdog_mem` (counter, clear/enable in, expiry pulse out). The rest stays flat.

Test Plan:
- Reset for 2 cycles mid-MEM_READ → all outputs 0 during reset; FETCH with `mem_read`=1 on the first cycle after release.
- R-type (opcode 000000), `mem_ready`=1 → R_EXEC with `alu_op`=10, `alu_src_b`=00; R_WB with `reg_write`=1, `reg_dst`=1; back in FETCH after exactly 4 edges.
- lw with `mem_ready` delayed 3 cycles in MEM_READ → `mem_read`=1, `i_or_d`=1 held 4 cycles; then MEM_WB with `mem_to_reg`=1; no `mem_timeout`.
- beq with `zero`=0 then `zero`=1 → BRANCH `pc_en`=0 and `pc_en`=1 respectively, `pc_source`=01, `alu_op`=01.
- Opcode 111111 → `illegal_op` single-cycle pulse in DECODE; next state FETCH; no `reg_write`/`mem_write` issued.
- `mem_ready` stuck 0 in FETCH, default `TIMEOUT_CYCLES`=16 → `mem_timeout` pulse on the 16th FETCH cycle, `ir_write`/`pc_en` never asserted, FETCH restarts with watchdog cleared.
